uart_transmitter: RTL and testbench

- Serializer that drives the CPU's FPGA_SERIAL_TX line.
- Counterpart to the receive path on FPGA_SERIAL_RX.
- Accepts bytes from the CPU memory-mapped I/O logic over a valid/ready handshake and buffers them in a small FIFO.
- Transmits each byte as an 8N1 frame: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity.

---
 rtl/uart_transmitter.sv | 178 +++++++++++++++++
 tb/tb_uart_transmitter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: buffers bytes from a valid/ready producer in a small
// circular FIFO and serialises each one as an 8N1 frame on serial_out.
module uart_transmitter #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_in_valid,
    output logic       data_in_ready,
    output logic       serial_out,
    output logic       busy
);

    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int CW = (SYMBOL_EDGE_TIME > 2) ? $clog2(SYMBOL_EDGE_TIME) : 1;
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] LAST_CYCLE = CW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    if (SYMBOL_EDGE_TIME < 2) begin : g_bad_baud
        $error("uart_transmitter: CLOCK_FREQ / BAUD_RATE must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_transmitter: FIFO_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Serializer state
    state_t        r_state;
    logic [CW-1:0] r_cycle;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic          r_tx;

    state_t        w_state_next;
    logic [CW-1:0] w_cycle_next;
    logic [2:0]    w_bit_next;
    logic          w_tx_next;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_sym_end;

    assign w_empty       = (r_count == '0);
    assign data_in_ready = (r_count != FULL_COUNT);
    assign w_push        = data_in_valid && data_in_ready;
    assign w_sym_end     = (r_cycle == LAST_CYCLE);
    assign serial_out    = r_tx;
    assign busy          = (r_state != S_IDLE) || !w_empty;

    // FIFO data array: written at the tail on every accepted byte
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Serializer registers: state, bit timing, line level, and the popped byte
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cycle   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_cycle   <= w_cycle_next;
            r_bit_idx <= w_bit_next;
            r_tx      <= w_tx_next;
            if (w_pop) begin
                r_shift <= r_mem[r_rd_ptr];
            end
        end
    end

    // Next-state logic; the line level is computed one cycle ahead so serial_out is registered
    always_comb begin
        w_state_next = r_state;
        w_cycle_next = r_cycle;
        w_bit_next   = r_bit_idx;
        w_tx_next    = r_tx;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_tx_next    = 1'b1;
                w_cycle_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_START;
                    w_tx_next    = 1'b0;
                end
            end
            S_START: begin
                if (w_sym_end) begin
                    w_state_next = S_DATA;
                    w_cycle_next = '0;
                    w_bit_next   = 3'd0;
                    w_tx_next    = r_shift[0];
                end else begin
                    w_cycle_next = r_cycle + CW'(1);
                end
            end
            S_DATA: begin
                if (w_sym_end) begin
                    w_cycle_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_bit_next = r_bit_idx + 3'd1;
                        w_tx_next  = r_shift[r_bit_idx + 3'd1];
                    end
                end else begin
                    w_cycle_next = r_cycle + CW'(1);
                end
            end
            S_STOP: begin
                if (w_sym_end) begin
                    w_cycle_next = '0;
                    // Chain straight into the next start bit so frames stay contiguous
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = S_START;
                        w_tx_next    = 1'b0;
                    end else begin
                        w_state_next = S_IDLE;
                        w_tx_next    = 1'b1;
                    end
                end else begin
                    w_cycle_next = r_cycle + CW'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_tx_next    = 1'b1;
                w_cycle_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Scoreboard bench for uart_transmitter: stimulus pushes expected bytes into a
// queue on each accept; a line monitor decodes frames and pops/compares them.
module tb_uart_transmitter;

    localparam int CF    = 1000;
    localparam int BR    = 100;
    localparam int DEPTH = 4;

    logic       clk           = 1'b0;
    logic       rst           = 1'b1;
    logic [7:0] data_in       = 8'h00;
    logic       data_in_valid = 1'b0;
    logic       data_in_ready;
    logic       serial_out;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] exp_q[$];
    int         stamps[$];

    uart_transmitter #(
        .CLOCK_FREQ(CF),
        .BAUD_RATE (BR),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .data_in_ready(data_in_ready),
        .serial_out   (serial_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Edge counter: at the falling edge after rising edge E, cyc == E
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line monitor: decodes 8N1 frames by sampling mid-bit (10 cycles per bit)
    bit         mon_active = 1'b0;
    int         mon_idx    = 0;
    logic [7:0] mon_byte   = 8'h00;

    always @(negedge clk) begin
        if (!rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (serial_out === 1'b0) begin
                mon_active = 1'b1;
                mon_idx    = 0;
                mon_byte   = 8'h00;
                stamps.push_back(cyc);
            end
        end else begin
            mon_idx++;
            if (mon_idx == 5) begin
                check("start_bit", {31'd0, serial_out}, 32'd0);
            end else if (mon_idx >= 15 && mon_idx <= 85 && (mon_idx % 10) == 5) begin
                mon_byte[(mon_idx - 15) / 10] = serial_out;
            end else if (mon_idx == 95) begin
                check("stop_bit", {31'd0, serial_out}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame: got byte %02h, none expected", mon_byte);
                end else begin
                    check("frame_byte", {24'd0, mon_byte}, {24'd0, exp_q.pop_front()});
                end
                mon_active = 1'b0;
            end
        end
    end

    // Called at a falling edge; holds valid until accepted, returns the accept edge
    task automatic send(input logic [7:0] b, output int acc);
        int w;
        w             = 0;
        data_in       = b;
        data_in_valid = 1'b1;
        while (data_in_ready !== 1'b1 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        check("accept_timeout", {31'd0, (w < 2000)}, 32'd1);
        acc = cyc + 1;
        exp_q.push_back(b);
        @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int w;
        w = 0;
        while (busy !== 1'b0 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check({name, "_idle_timeout"}, {31'd0, (w < 5000)}, 32'd1);
        repeat (3) @(negedge clk);
        check({name, "_drained"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int a[6];
        int lows;
        int busys;
        logic [7:0] t5[5];

        // Reset state
        #1 rst = 1'b0;
        #1;
        check("rst_serial", {31'd0, serial_out}, 32'd1);
        check("rst_ready", {31'd0, data_in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5: timing of start, first data bit, stop and busy
        send(8'hA5, e);
        data_in_valid = 1'b0;
        data_in       = 8'h00;
        check("t1_busy_on_accept", {31'd0, busy}, 32'd1);
        check("t1_no_bypass", {31'd0, serial_out}, 32'd1);
        wait_until(e + 1);
        check("t1_start_first", {31'd0, serial_out}, 32'd0);
        wait_until(e + 10);
        check("t1_start_last", {31'd0, serial_out}, 32'd0);
        wait_until(e + 11);
        check("t1_bit0", {31'd0, serial_out}, 32'd1);
        wait_until(e + 21);
        check("t1_bit1", {31'd0, serial_out}, 32'd0);
        wait_until(e + 100);
        check("t1_stop_last", {31'd0, serial_out}, 32'd1);
        check("t1_busy_in_stop", {31'd0, busy}, 32'd1);
        wait_until(e + 101);
        check("t1_busy_fall", {31'd0, busy}, 32'd0);
        check("t1_idle_high", {31'd0, serial_out}, 32'd1);
        wait_idle("t1");

        // Back-to-back 0x01..0x06 with backpressure
        stamps.delete();
        for (int k = 0; k < 6; k++) send(8'(k + 1), a[k]);
        data_in_valid = 1'b0;
        for (int k = 1; k < 5; k++) check("t2_consecutive_accept", a[k], a[0] + k);
        check("t2_sixth_after_pop", a[5], a[0] + 102);
        wait_idle("t2");
        check("t2_frame_count", stamps.size(), 32'd6);
        if (stamps.size() == 6) begin
            check("t2_first_start", stamps[0], a[0] + 1);
            for (int k = 1; k < 6; k++) check("t2_no_gap", stamps[k] - stamps[k - 1], 32'd100);
        end

        // Simultaneous push and pop with 3 bytes buffered
        send(8'hB0, e);
        send(8'hB1, a[0]);
        send(8'hB2, a[0]);
        send(8'hB3, a[0]);
        data_in_valid = 1'b0;
        wait_until(e + 100);
        send(8'hB4, a[0]);
        check("t3_push_on_pop_edge", a[0], e + 101);
        check("t3_ready_kept", {31'd0, data_in_ready}, 32'd1);
        send(8'hB5, a[1]);
        data_in_valid = 1'b0;
        check("t3_count_was_3", {31'd0, data_in_ready}, 32'd0);
        wait_idle("t3");

        // Reset during data bit 3 of 0x3C with 2 bytes queued
        send(8'h3C, e);
        send(8'h77, a[0]);
        send(8'h88, a[0]);
        data_in_valid = 1'b0;
        wait_until(e + 45);
        #2 rst = 1'b0;
        exp_q.delete();
        #1;
        check("t4_rst_serial", {31'd0, serial_out}, 32'd1);
        check("t4_rst_busy", {31'd0, busy}, 32'd0);
        check("t4_rst_ready", {31'd0, data_in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst   = 1'b1;
        lows  = 0;
        busys = 0;
        repeat (300) begin
            @(negedge clk);
            if (serial_out !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        check("t4_silent_line", lows, 32'd0);
        check("t4_not_busy", busys, 32'd0);

        // Loopback-style pattern bytes decoded by the monitor
        t5 = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h80};
        for (int k = 0; k < 5; k++) send(t5[k], a[0]);
        data_in_valid = 1'b0;
        wait_idle("t5");

        // Pointer wrap: 3 x depth bytes under backpressure
        for (int k = 0; k < 3 * DEPTH; k++) send(8'(8'h10 + k), a[0]);
        data_in_valid = 1'b0;
        wait_idle("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
